clk_div_arbiter: RTL

Shared programmable clock divider with a round-robin arbiter in front of it. Up to N_REQ requesters each present a divide ratio; the block grants one requester at a time, loads its ratio into an embedded divide counter, and generates clk_out plus a per-period tick. Ownership changes only at a completed output period, so clk_out never produces a runt pulse. It sits between peripheral blocks that need slow clocks and the single counter resource in the clocking subsystem.

---
 rtl/clk_div_arbiter_pkg.sv | 19 +
 rtl/clk_div_core.sv | 92 +++++++++
 rtl/clk_div_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/clk_div_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_arbiter_pkg
// Shared definitions for the clock divider arbiter: FSM state encoding, the
// default divide-counter width and the minimum legal divide ratio.
// -----------------------------------------------------------------------------
package clk_div_arbiter_pkg;

  localparam int CNT_W_DEF = 23;  // default counter / ratio width
  localparam int DIV_MIN   = 2;   // ratios 0 and 1 are clamped up to this

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOAD,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/clk_div_core.sv
// -----------------------------------------------------------------------------
// clk_div_core
// Divide counter with registered clk_out / tick generation.
// Optional feature macro: CLK_DIV_ARB_ODD_DUTY_EN adds a negedge stage that
// stretches the high phase by half a clk_in cycle for odd ratios (50% duty).
//
// Ports
//   clk_in   source clock
//   reset    asynchronous, active-low reset
//   load     high in the cycle before counting starts (count restarts at 0)
//   run      keep counting into the next cycle
//   div_q    latched divide ratio (>= 2)
//   clk_out  divided clock
//   tick     high on the last clk_in cycle of each output period
//   wrap     current count is the last of the period (div_q-1)
// -----------------------------------------------------------------------------
module clk_div_core
  import clk_div_arbiter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] div_q,
  output logic             clk_out,
  output logic             tick,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] last_cnt;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  assign last_cnt = div_q - ONE;
  assign wrap     = (count_q == last_cnt);

  // clk_out and tick are decoded from the next count so the registered
  // outputs line up with the count value of the same cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    count_d = '0;
    if (run && !wrap) count_d = count_q + ONE;
    clk_out_d = (load || run) && (count_d < (div_q >> 1));
    tick_d    = (load || run) && (count_d == last_cnt);
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      count_q   <= count_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

`ifdef CLK_DIV_ARB_ODD_DUTY_EN
  logic active_q;
  logic ext_q;

  // active_q is low in LOAD and in the cycle after release, clearing the
  // half-cycle extension there.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) active_q <= 1'b0;
    else        active_q <= load || run;
  end

  // Half-cycle delayed copy of the high phase, only used for odd ratios.
  always_ff @(negedge clk_in or negedge reset) begin
    if (!reset)         ext_q <= 1'b0;
    else if (!active_q) ext_q <= 1'b0;
    else                ext_q <= clk_out_q & div_q[0];
  end

  assign clk_out = clk_out_q | ext_q;
`else
  assign clk_out = clk_out_q;
`endif

endmodule

// File: rtl/clk_div_arbiter.sv
// -----------------------------------------------------------------------------
// clk_div_arbiter
// Round-robin arbiter in front of a shared programmable clock divider. One
// requester owns the divider at a time; ownership only changes at the end of
// a complete output period so clk_out never produces a runt pulse.
// Optional feature macro: CLK_DIV_ARB_ODD_DUTY_EN (see clk_div_core).
//
// Ports
//   clk_in   source clock
//   reset    asynchronous, active-low reset
//   req      per-requester request level
//   req_div  packed ratios, slice i = [i*CNT_W +: CNT_W]
//   gnt      one-hot grant, zero when the divider is unowned
//   clk_out  divided clock
//   tick     one-cycle pulse on the last clk_in cycle of each period
//   busy     high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module clk_div_arbiter
  import clk_div_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_div,
  output logic [N_REQ-1:0]       gnt,
  output logic                   clk_out,
  output logic                   tick,
  output logic                   busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [PTR_W-1:0] pick;
  logic [CNT_W-1:0] pick_div;
  logic             wrap;
  logic             granted_req;
  logic             release_w;
  logic             run;
  logic             load;

  // First asserted request at or after rr_q, wrapping. Scanning from the
  // lowest priority upwards lets the highest-priority hit win last.
  always_comb begin
    pick = rr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_q) + i) % N_REQ]) pick = PTR_W'((int'(rr_q) + i) % N_REQ);
    end
  end

  assign pick_div = req_div[int'(pick)*CNT_W +: CNT_W];

  assign granted_req = |(req & gnt_q);
  // The owner lets go at the end of a period: either in DRAIN, or in RUN when
  // its request is already gone on the last count (no extra period).
  assign release_w = wrap && ((state_q == DRAIN) || (state_q == RUN && !granted_req));
  assign run       = ((state_q == RUN) || (state_q == DRAIN)) && !release_w;
  assign load      = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign gnt       = gnt_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    div_d   = div_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    unique case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        if (|req) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          gidx_d      = pick;
          div_d       = (pick_div < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : pick_div;
          state_d     = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: state_d = RUN;
      RUN, DRAIN: begin
        if (release_w) begin
          gnt_d   = '0;
          rr_d    = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
          state_d = (|req) ? ARB : IDLE;
        end else if (state_q == RUN && !granted_req) begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      div_q   <= '0;
      rr_q    <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      div_q   <= div_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
    end
  end

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk_in (clk_in),
    .reset  (reset),
    .load   (load),
    .run    (run),
    .div_q  (div_q),
    .clk_out(clk_out),
    .tick   (tick),
    .wrap   (wrap)
  );

endmodule
